// File: rtl/draw_pkg.sv
// Shared drawing constants, coordinate widths and the rectangle sweep state encoding.
// Used by rect_reader and rect_scan_counter.
package draw_pkg;

    localparam int X_W      = 10;
    localparam int Y_W      = 9;
    localparam int COLOR_W  = 3;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COUNT_W  = X_W + Y_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/rect_scan_counter.sv
// Raster offset generator for a rectangle sweep: column offset inner, row offset outer.
// Flags whether the current pixel lies on screen and whether it is the last one.
module rect_scan_counter
    import draw_pkg::*;
(
    input  logic           clock,
    input  logic           resetn,
    input  logic           clear,
    input  logic           advance,
    input  logic [X_W-1:0] base_x,
    input  logic [Y_W-1:0] base_y,
    input  logic [X_W-1:0] width,
    input  logic [Y_W-1:0] height,
    output logic [X_W-1:0] cx,
    output logic [Y_W-1:0] cy,
    output logic           in_bounds,
    output logic           last_pixel
);

    logic [X_W-1:0] cx_reg;
    logic [Y_W-1:0] cy_reg;
    logic [X_W:0]   pix_x;
    logic [Y_W:0]   pix_y;
    logic           row_end;

    assign row_end = (cx_reg == width - X_W'(1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cx_reg <= '0;
            cy_reg <= '0;
        end else if (clear) begin
            cx_reg <= '0;
            cy_reg <= '0;
        end else if (advance) begin
            if (row_end) begin
                cx_reg <= '0;
                cy_reg <= cy_reg + Y_W'(1);
            end else begin
                cx_reg <= cx_reg + X_W'(1);
            end
        end
    end

    // One extra bit so a rectangle hanging past the right/bottom edge cannot wrap back on screen.
    assign pix_x      = {1'b0, base_x} + {1'b0, cx_reg};
    assign pix_y      = {1'b0, base_y} + {1'b0, cy_reg};
    assign in_bounds  = (pix_x < (X_W+1)'(SCREEN_W)) && (pix_y < (Y_W+1)'(SCREEN_H));
    assign last_pixel = row_end && (cy_reg == height - Y_W'(1));
    assign cx         = cx_reg;
    assign cy         = cy_reg;

endmodule

// File: rtl/rect_reader.sv
// Sweeps a framebuffer rectangle through the synchronous read port and reports colour hits.
// Build option RECT_READER_EARLY_EXIT_EN: stop issuing reads at the first matching pixel.
module rect_reader
    import draw_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic [X_W-1:0]     x,
    input  logic [Y_W-1:0]     y,
    input  logic [X_W-1:0]     width,
    input  logic [Y_W-1:0]     height,
    input  logic [COLOR_W-1:0] match_color,
    output logic [X_W-1:0]     rd_x,
    output logic [Y_W-1:0]     rd_y,
    output logic               rd_en,
    input  logic [COLOR_W-1:0] rd_data,
    output logic               busy,
    output logic               done,
    output logic               hit,
    output logic [COUNT_W-1:0] match_count,
    output logic [X_W-1:0]     hit_x,
    output logic [Y_W-1:0]     hit_y
);

    state_t             state_reg, state_next;
    logic [X_W-1:0]     x_reg, w_reg;
    logic [Y_W-1:0]     y_reg, h_reg;
    logic [COLOR_W-1:0] color_reg;
    logic [2:0]         drain_cnt_reg;
    logic               hit_reg;
    logic [COUNT_W-1:0] count_reg;
    logic [X_W-1:0]     hit_x_reg;
    logic [Y_W-1:0]     hit_y_reg;

    logic [X_W-1:0]     cx;
    logic [Y_W-1:0]     cy;
    logic               in_bounds, last_pixel;
    logic               accept, empty_rect, sample_match, count_en, stop_scan;

    logic [RD_LATENCY-1:0] valid_pipe_reg, valid_pipe_next;
    logic [X_W-1:0]        px_pipe_reg [RD_LATENCY];
    logic [X_W-1:0]        px_pipe_next[RD_LATENCY];
    logic [Y_W-1:0]        py_pipe_reg [RD_LATENCY];
    logic [Y_W-1:0]        py_pipe_next[RD_LATENCY];

    genvar gi;

    assign accept     = (state_reg == IDLE) && start;
    assign empty_rect = (width == '0) || (height == '0);

    rect_scan_counter u_scan (
        .clock      (clock),
        .resetn     (resetn),
        .clear      (accept),
        .advance    (state_reg == SCAN),
        .base_x     (x_reg),
        .base_y     (y_reg),
        .width      (w_reg),
        .height     (h_reg),
        .cx         (cx),
        .cy         (cy),
        .in_bounds  (in_bounds),
        .last_pixel (last_pixel)
    );

    // Valid flag and coordinates travel alongside each read so a return can be attributed.
    generate
        for (gi = 0; gi < RD_LATENCY; gi++) begin : g_ret_pipe
            if (gi == 0) begin : g_head
                assign valid_pipe_next[gi] = rd_en;
                assign px_pipe_next[gi]    = rd_x;
                assign py_pipe_next[gi]    = rd_y;
            end else begin : g_tail
                assign valid_pipe_next[gi] = valid_pipe_reg[gi-1];
                assign px_pipe_next[gi]    = px_pipe_reg[gi-1];
                assign py_pipe_next[gi]    = py_pipe_reg[gi-1];
            end
        end
    endgenerate

    assign sample_match = valid_pipe_reg[RD_LATENCY-1] && (rd_data == color_reg);

`ifdef RECT_READER_EARLY_EXIT_EN
    // Only the first hit counts; anything still in flight after it is discarded.
    assign count_en  = sample_match && !hit_reg;
    assign stop_scan = count_en;
`else
    assign count_en  = sample_match;
    assign stop_scan = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = empty_rect ? DONE : SCAN;
            SCAN:    if (last_pixel || stop_scan) state_next = DRAIN;
            DRAIN:   if (drain_cnt_reg == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_en = 1'b0;
        rd_x  = '0;
        rd_y  = '0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_reg)
            SCAN: begin
                rd_en = in_bounds;
                rd_x  = x_reg + cx;
                rd_y  = y_reg + cy;
                busy  = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_reg          <= '0;
            y_reg          <= '0;
            w_reg          <= '0;
            h_reg          <= '0;
            color_reg      <= '0;
            drain_cnt_reg  <= '0;
            hit_reg        <= 1'b0;
            count_reg      <= '0;
            hit_x_reg      <= '0;
            hit_y_reg      <= '0;
            valid_pipe_reg <= '0;
            px_pipe_reg    <= '{default: '0};
            py_pipe_reg    <= '{default: '0};
        end else begin
            if (accept) begin
                x_reg     <= x;
                y_reg     <= y;
                w_reg     <= width;
                h_reg     <= height;
                color_reg <= match_color;
                hit_reg   <= 1'b0;
                count_reg <= '0;
            end else if (count_en) begin
                count_reg <= sat_inc(count_reg);
                if (!hit_reg) begin
                    hit_reg   <= 1'b1;
                    hit_x_reg <= px_pipe_reg[RD_LATENCY-1];
                    hit_y_reg <= py_pipe_reg[RD_LATENCY-1];
                end
            end

            // Preloaded outside DRAIN so the drain lasts exactly RD_LATENCY cycles.
            if (state_reg != DRAIN) begin
                drain_cnt_reg <= 3'(RD_LATENCY - 1);
            end else if (drain_cnt_reg != '0) begin
                drain_cnt_reg <= drain_cnt_reg - 3'd1;
            end

            valid_pipe_reg <= valid_pipe_next;
            px_pipe_reg    <= px_pipe_next;
            py_pipe_reg    <= py_pipe_next;
        end
    end

    assign hit         = hit_reg;
    assign match_count = count_reg;
    assign hit_x       = hit_x_reg;
    assign hit_y       = hit_y_reg;

endmodule

// File: tb/tb_rect_reader.sv
// Scoreboard bench for rect_reader: two instances (read latency 1 and 3) against a pixel-level model.
module tb_rect_reader;
    import draw_pkg::*;

`ifdef RECT_READER_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct { int x; int y; } rd_t;
    typedef struct { int done_cyc; int hit; int cnt; int hx; int hy; } res_t;

    logic clock = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   cur = 0;

    logic               start_s [2];
    logic [X_W-1:0]     x_s [2];
    logic [Y_W-1:0]     y_s [2];
    logic [X_W-1:0]     width_s [2];
    logic [Y_W-1:0]     height_s [2];
    logic [COLOR_W-1:0] mc_s [2];
    logic [X_W-1:0]     rd_x_s [2];
    logic [Y_W-1:0]     rd_y_s [2];
    logic               rd_en_s [2];
    logic               busy_s [2];
    logic               done_s [2];
    logic               hit_s [2];
    logic [COUNT_W-1:0] match_count_s [2];
    logic [X_W-1:0]     hit_x_s [2];
    logic [Y_W-1:0]     hit_y_s [2];
    logic [COLOR_W-1:0] ret0_q;
    logic [COLOR_W-1:0] ret1_q [3];

    int                 mem_mode = 0;
    int                 mem_seed = 0;
    int                 mem_tx = 0;
    int                 mem_ty = 0;
    logic [COLOR_W-1:0] mem_mc = '0;

    rd_t  rd_q[$];
    res_t exp_q[$];
    rd_t  mon_r;
    res_t mon_e;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    rect_reader #(.RD_LATENCY(1)) dut0 (
        .clock(clock), .resetn(resetn), .start(start_s[0]), .x(x_s[0]), .y(y_s[0]),
        .width(width_s[0]), .height(height_s[0]), .match_color(mc_s[0]),
        .rd_x(rd_x_s[0]), .rd_y(rd_y_s[0]), .rd_en(rd_en_s[0]), .rd_data(ret0_q),
        .busy(busy_s[0]), .done(done_s[0]), .hit(hit_s[0]), .match_count(match_count_s[0]),
        .hit_x(hit_x_s[0]), .hit_y(hit_y_s[0])
    );

    rect_reader #(.RD_LATENCY(3)) dut1 (
        .clock(clock), .resetn(resetn), .start(start_s[1]), .x(x_s[1]), .y(y_s[1]),
        .width(width_s[1]), .height(height_s[1]), .match_color(mc_s[1]),
        .rd_x(rd_x_s[1]), .rd_y(rd_y_s[1]), .rd_en(rd_en_s[1]), .rd_data(ret1_q[2]),
        .busy(busy_s[1]), .done(done_s[1]), .hit(hit_s[1]), .match_count(match_count_s[1]),
        .hit_x(hit_x_s[1]), .hit_y(hit_y_s[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Framebuffer contents as a function of position; the active pattern is chosen per test.
    function automatic logic [COLOR_W-1:0] pix_color(input int px, input int py);
        case (mem_mode)
            0:       return COLOR_W'((px * 5) ^ (py * 3) ^ mem_seed);
            1:       return mem_mc;
            default: return (px == mem_tx && py == mem_ty) ? mem_mc : (mem_mc ^ COLOR_W'(1));
        endcase
    endfunction

    // Read ports: unread cycles return random garbage that must be ignored.
    always @(posedge clock) begin
        ret0_q    <= rd_en_s[0] ? pix_color(int'(rd_x_s[0]), int'(rd_y_s[0])) : COLOR_W'($urandom);
        ret1_q[0] <= rd_en_s[1] ? pix_color(int'(rd_x_s[1]), int'(rd_y_s[1])) : COLOR_W'($urandom);
        ret1_q[1] <= ret1_q[0];
        ret1_q[2] <= ret1_q[1];
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: walk the rectangle pixel by pixel, listing issued reads and the final result.
    task automatic predict(input int d, input int rx, input int ry, input int rw, input int rh,
                           input logic [COLOR_W-1:0] mc, input int s);
        int   lat, n, idx, last_issue, cnt, hx, hy;
        bit   found;
        rd_t  r;
        res_t e;
        lat = lat_of(d);
        n = rw * rh;
        idx = 0;
        last_issue = n - 1;
        cnt = 0; hx = 0; hy = 0; found = 1'b0;
        for (int cy = 0; cy < rh; cy++) begin
            for (int cx = 0; cx < rw; cx++) begin
                int px, py;
                px = rx + cx;
                py = ry + cy;
                if (idx <= last_issue && px < SCREEN_W && py < SCREEN_H) begin
                    r.x = px; r.y = py;
                    rd_q.push_back(r);
                    if (pix_color(px, py) == mc && !(EARLY && found)) begin
                        if (!found) begin
                            found = 1'b1; hx = px; hy = py;
                            // The hit is seen lat cycles after its read; reads issued meanwhile still go out.
                            if (EARLY && idx + lat < n - 1) last_issue = idx + lat;
                        end
                        cnt++;
                    end
                end
                idx++;
            end
        end
        e.done_cyc = (n == 0) ? s + 1 : s + last_issue + 2 + lat;
        e.hit = found ? 1 : 0;
        e.cnt = cnt;
        e.hx  = hx;
        e.hy  = hy;
        exp_q.push_back(e);
        $display("op dut%0d x=%0d y=%0d w=%0d h=%0d mc=%0d -> reads=%0d hit=%0d count=%0d done@%0d",
                 d, rx, ry, rw, rh, mc, rd_q.size(), e.hit, cnt, e.done_cyc);
    endtask

    always @(negedge clock) begin
        if (resetn) begin
            if (rd_en_s[cur]) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: got (%0d,%0d) expected none", rd_x_s[cur], rd_y_s[cur]);
                end else begin
                    mon_r = rd_q.pop_front();
                    chk("rd_x", int'(rd_x_s[cur]), mon_r.x);
                    chk("rd_y", int'(rd_y_s[cur]), mon_r.y);
                end
            end
            if (done_s[cur]) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1 expected 0 at cycle %0d", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done_cycle", cyc, mon_e.done_cyc);
                    chk("busy_at_done", int'(busy_s[cur]), 0);
                    chk("hit", int'(hit_s[cur]), mon_e.hit);
                    chk("match_count", int'(match_count_s[cur]), mon_e.cnt);
                    if (mon_e.hit != 0) begin
                        chk("hit_x", int'(hit_x_s[cur]), mon_e.hx);
                        chk("hit_y", int'(hit_y_s[cur]), mon_e.hy);
                    end
                end
            end
            if (rd_en_s[1-cur] || done_s[1-cur]) begin
                checks++; errors++;
                $display("FAIL idle_dut_active: dut%0d rd_en=%0d done=%0d expected 0", 1 - cur,
                         rd_en_s[1-cur], done_s[1-cur]);
            end
        end
    end

    task automatic issue(input int d, input int rx, input int ry, input int rw, input int rh,
                         input logic [COLOR_W-1:0] mc);
        @(posedge clock); #1;
        cur = d;
        predict(d, rx, ry, rw, rh, mc, cyc);
        start_s[d]  = 1'b1;
        x_s[d]      = X_W'(rx);
        y_s[d]      = Y_W'(ry);
        width_s[d]  = X_W'(rw);
        height_s[d] = Y_W'(rh);
        mc_s[d]     = mc;
        @(posedge clock); #1;
        start_s[d]  = 1'b0;
        x_s[d]      = X_W'($urandom);
        y_s[d]      = Y_W'($urandom);
        width_s[d]  = X_W'($urandom);
        height_s[d] = Y_W'($urandom);
        mc_s[d]     = COLOR_W'($urandom);
    endtask

    task automatic wait_done(input int d, input int budget);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(posedge clock); #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL timeout: dut%0d gave no done within %0d cycles", d, budget);
            exp_q.delete();
        end
        chk("reads_missing", rd_q.size(), 0);
        rd_q.delete();
        chk("busy_after", int'(busy_s[d]), 0);
    endtask

    task automatic run_op(input int d, input int rx, input int ry, input int rw, input int rh,
                          input logic [COLOR_W-1:0] mc);
        issue(d, rx, ry, rw, rh, mc);
        wait_done(d, rw * rh + 2 * lat_of(d) + 10);
    endtask

    task automatic set_mem(input int mode, input logic [COLOR_W-1:0] mc, input int tx, input int ty);
        mem_mode = mode; mem_mc = mc; mem_tx = tx; mem_ty = ty;
        mem_seed = int'($urandom_range(0, 7));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0; x_s[d] = '0; y_s[d] = '0;
            width_s[d] = '0; height_s[d] = '0; mc_s[d] = '0;
        end
        resetn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", int'(busy_s[d]), 0);
            chk("rst_done", int'(done_s[d]), 0);
            chk("rst_hit", int'(hit_s[d]), 0);
            chk("rst_count", int'(match_count_s[d]), 0);
            chk("rst_rd_en", int'(rd_en_s[d]), 0);
            chk("rst_rd_x", int'(rd_x_s[d]), 0);
        end
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;

        // Single match inside a small rectangle.
        set_mem(2, 3'd3, 11, 21);
        run_op(0, 10, 20, 3, 2, 3'd3);
        // Zero width: no reads, immediate done.
        set_mem(1, 3'd4, 0, 0);
        run_op(0, 5, 5, 0, 5, 3'd4);
        // Straddling the right edge.
        set_mem(1, 3'd6, 0, 0);
        run_op(0, 638, 0, 4, 1, 3'd6);
        // Longer read latency, everything matches.
        set_mem(1, 3'd2, 0, 0);
        run_op(1, 30, 40, 2, 2, 3'd2);
        // Lone match early in a row (early-exit case when that build option is on).
        set_mem(2, 3'd5, 102, 7);
        run_op(0, 100, 7, 8, 1, 3'd5);
        set_mem(2, 3'd1, 202, 9);
        run_op(1, 200, 9, 8, 1, 3'd1);

        // Second start mid-scan is ignored; reset mid-scan aborts without a done pulse.
        set_mem(1, 3'd7, 0, 0);
        issue(0, 100, 50, 20, 3, 3'd7);
        repeat (5) @(posedge clock);
        #1 start_s[0] = 1'b1; x_s[0] = '0; y_s[0] = '0; width_s[0] = 10'd1; height_s[0] = 9'd1;
        @(posedge clock); #1 start_s[0] = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("mid_busy", int'(busy_s[0]), 1);
        chk("mid_hit", int'(hit_s[0]), 1);
        resetn = 1'b0;
        #1;
        chk("abort_busy", int'(busy_s[0]), 0);
        chk("abort_hit", int'(hit_s[0]), 0);
        chk("abort_count", int'(match_count_s[0]), 0);
        chk("abort_done", int'(done_s[0]), 0);
        chk("abort_rd_en", int'(rd_en_s[0]), 0);
        rd_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        set_mem(0, 3'd0, 0, 0);
        run_op(0, 50, 60, 6, 3, 3'd2);

        // Random rectangles, some hanging off the right or bottom edge.
        for (int i = 0; i < 24; i++) begin
            int d, rx, ry;
            d  = i % 2;
            rx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(630, 1023)) : int'($urandom_range(0, 639));
            ry = ($urandom_range(0, 3) == 0) ? int'($urandom_range(470, 511)) : int'($urandom_range(0, 479));
            set_mem(int'($urandom_range(0, 2)), COLOR_W'($urandom), rx + int'($urandom_range(0, 4)), ry);
            run_op(d, rx, ry, int'($urandom_range(0, 10)), int'($urandom_range(0, 5)), COLOR_W'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rect_reader.md
Name: rect_reader

Overview:
- Read-side counterpart of the rectangle drawer: sweeps a rectangle of the framebuffer, issuing pixel read addresses instead of write coordinates.
- Compares each returned pixel colour against a target colour and reports hit status, match count and first-hit coordinates.
- Used by game logic for collision and overlap tests against what is already on screen.
- Sits between the game FSM and the framebuffer's synchronous read port.

Parameters:
- COLOR_W, 3, width of the pixel colour bus.
- SCREEN_W, 640, visible columns; x >= SCREEN_W is off-screen.
- SCREEN_H, 480, visible rows; y >= SCREEN_H is off-screen.
- RD_LATENCY, 1, cycles from rd_en to valid rd_data (1..4).

Ports:
- clock  in  1  system clock, all logic on posedge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- x  in  10  rectangle left column.
- y  in  9  rectangle top row.
- width  in  10  rectangle width in pixels.
- height  in  9  rectangle height in pixels.
- match_color  in  COLOR_W  colour counted as a hit.
- rd_x  out  10  framebuffer read column.
- rd_y  out  9  framebuffer read row.
- rd_en  out  1  read strobe, one pixel per cycle.
- rd_data  in  COLOR_W  pixel colour, valid RD_LATENCY cycles after rd_en.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when results are final.
- hit  out  1  at least one matching pixel found (held until next start).
- match_count  out  19  number of matching pixels (held until next start).
- hit_x  out  10  column of first match (held).
- hit_y  out  9  row of first match (held).

Behaviour:
- Reset (async, resetn=0): state IDLE. rd_en, busy, done, hit = 0. match_count, hit_x, hit_y, rd_x, rd_y = 0. Any in-flight tracking is cleared.
- States:
  - IDLE: on start, latch x, y, width, height, match_color; clear hit and match_count; set busy. Go to SCAN, or straight to DONE if width==0 or height==0.
  - SCAN: one pixel per cycle in raster order, column offset inner, row offset outer. rd_x = x+cx, rd_y = y+cy, widened to 11/10 bits for the bounds check. Pixels outside SCREEN_W/SCREEN_H get rd_en=0 and count as non-matching; the scan still steps through them. After the last pixel (cx=width-1, cy=height-1), go to DRAIN.
  - DRAIN: wait RD_LATENCY cycles for outstanding returns, then go to DONE.
  - DONE: done=1 for exactly one cycle, busy drops in the same cycle, then IDLE.
- Latency for an in-range rectangle: done asserts width*height + RD_LATENCY + 1 cycles after the start cycle.
- Return tracking: a RD_LATENCY-deep valid shift register plus matching coordinate pipeline. Each returned sample with valid=1 and rd_data==match_color increments match_count.
- First hit: the first such sample sets hit and captures hit_x/hit_y from the coordinate pipeline. Later hits do not overwrite them.
- start while busy is ignored. Inputs are only sampled at acceptance; later changes have no effect.
- Reset mid-scan aborts immediately; no done pulse is produced.
- match_count saturates at 2^19-1. This is unreachable for legal sizes and exists only as a guard.

Optional Feature:
- Macro RECT_READER_EARLY_EXIT_EN.
- Defined: on the first hit, stop issuing reads (rd_en=0) and go to DRAIN. Returns still in flight are discarded, so match_count = 1 and done arrives early.
- Undefined: the full rectangle is always scanned and match_count is exact.

Decomposition:
- Shared package (draw_pkg):
  - screen dimension constants SCREEN_W/SCREEN_H and coordinate widths (X_W=10, Y_W=9).
  - COLOR_W.
  - state enum {IDLE, SCAN, DRAIN, DONE}.
- One sub-module, rect_scan_counter: generates cx/cy, the in-bounds flag and the last-pixel flag. It is shared with a future rework of the rectangle drawer.
- The latency pipeline stays inline.

Test Plan:
- Rect x=10,y=20,w=3,h=2, RD_LATENCY=1, memory returns match_color only at (11,21) -> rd sequence (10,20),(11,20),(12,20),(10,21),(11,21),(12,21); done 8 cycles after start; hit=1, match_count=1, hit_x=11, hit_y=21.
- width=0, height=5 -> no rd_en, done the cycle after acceptance, hit=0, match_count=0.
- Rect x=638,y=0,w=4,h=1 with all memory = match_color -> rd_en only for x=638,639; match_count=2; done still at cycle 4+1+1.
- RD_LATENCY=3, w=2,h=2, all pixels match -> match_count=4, first hit (x,y); done 8 cycles after start.
- Pulse start again mid-scan, then assert resetn=0 mid-scan -> second start ignored; reset clears busy/hit/count immediately with no done pulse; a new start afterwards works normally.
- With RECT_READER_EARLY_EXIT_EN, w=8,h=1, match at offset 2 -> rd_en stops after offset 3 (offset 2's return arrives while offset 3 is issued); match_count=1; done well before cycle 10.
